commit_trace_buffer: RTL and testbench
======================================

Name: commit_trace_buffer

Overview:
- Sits between the pipeline's EX/MEM and MEM/WB registers and the golden-trace checker.
- Captures every architectural commit (register write-back, load write-back, store, trap) into an in-order record stream.
- Decouples checker consumption from pipeline commit rate through a dual-write / single-read FIFO with a valid/ready output.
- Lets the checker compare one record per handshake instead of sampling pipeline internals.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 4.
- XLEN, 32, data/address width.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- wb_valid  in  1  MEM/WB write-back commit (regWEn && rd != 0).
- wb_is_load  in  1  write-back originates from a load.
- wb_pc  in  XLEN  PC of the write-back instruction.
- wb_instr  in  32  encoding of the write-back instruction.
- wb_rd  in  5  destination register.
- wb_data  in  XLEN  value written to the register file.
- wb_addr  in  XLEN  load address (ignored unless wb_is_load).
- st_valid  in  1  EX/MEM store commit (MemRW).
- st_pc  in  XLEN  PC of the store.
- st_instr  in  32  encoding of the store.
- st_addr  in  XLEN  store address.
- st_data  in  XLEN  store data.
- trap_valid  in  1  MEM/WB trap request (ECALL/EBREAK).
- trap_pc  in  XLEN  PC of the trapping instruction.
- rec_valid  out  1  output record available.
- rec_ready  in  1  checker accepts the record.
- rec_kind  out  2  record kind: REG=0, LOAD=1, STORE=2, TRAP=3.
- rec_pc  out  XLEN  PC of the record.
- rec_instr  out  32  instruction encoding (0 for TRAP).
- rec_rd  out  5  destination register (0 for STORE/TRAP).
- rec_data  out  XLEN  write-back value or store data.
- rec_addr  out  XLEN  memory address (0 for REG/TRAP).
- overflow  out  1  sticky; set when any record is dropped.
- done  out  1  trap record consumed; stream finished.
- commit_cnt  out  32  records accepted into the FIFO.

Behaviour:
- Reset (synchronous, clk edge with reset=1) clears all outputs and state:
  - rec_valid=0; all rec_* fields=0.
  - overflow=0, done=0, commit_cnt=0.
  - FIFO empty; state RUN.
- Reset has priority over every other input; FIFO contents are discarded.
- FIFO is show-ahead: rec_* present the head entry combinationally from storage.
  - rec_valid = !empty.
  - Pop occurs when rec_valid && rec_ready.
- Up to two pushes per cycle. Order when several events coincide: wb (or trap) first, then store. The MEM/WB instruction is older than the EX/MEM one.
- Trap takes the wb slot; wb_valid and trap_valid are never asserted together. If they are, trap wins and wb is dropped with overflow set.
- Free-space check counts the same-cycle pop: free = DEPTH - count + pop.
  - If free < number of pushes, the older record is written first, the remainder is dropped, and overflow is set.
  - Dropped records do not increment commit_cnt.
- Push into a full FIFO with a simultaneous pop succeeds.
- Pointers are log2(DEPTH)+1 bits and wrap naturally; count = wptr - rptr.
- commit_cnt increments by 0, 1 or 2 per cycle (records actually written) and wraps at 2^32.
- State machine (2-bit):
  - RUN: accept pushes. On an accepted trap push -> DRAIN; any store pushed in the same cycle is discarded, since it is younger than the trap.
  - DRAIN: ignore all inputs; keep popping. When the TRAP record pops -> DONE.
  - DONE: done=1, rec_valid=0; ignore inputs until reset.
  - A trap that is dropped for lack of space still moves to DRAIN; done then asserts when the FIFO empties.
- Latency: a commit accepted at edge N is visible on rec_* after edge N when the FIFO was empty.
- Field zeroing per kind is done at push time, not at output.

Decomposition:
- Package commit_trace_pkg holds:
  - the kind localparams (KIND_REG, KIND_LOAD, KIND_STORE, KIND_TRAP);
  - the packed commit record layout (kind, pc, instr, rd, data, addr = 135 bits at XLEN=32);
  - the state encoding (RUN, DRAIN, DONE).
- One sub-module, trace_fifo_2w1r: dual-write, single-read storage with pointers and a count output.
- Record packing, drop logic, counters and the FSM live in the top.

Test Plan:
- Single REG commit: wb_valid=1, pc=0x80000000, rd=5, data=0x12345678, rec_ready=1 -> next cycle rec_kind=0, rec_rd=5, rec_data=0x12345678, commit_cnt=1.
- Simultaneous load + store: wb (is_load, pc=0x80000010, rd=3, data=0xDEADBEEF, addr=0x100) and st (pc=0x80000014, addr=0x104, data=0xCAFEF00D) in one cycle -> LOAD record popped before STORE record; commit_cnt=2.
- Full FIFO: rec_ready=0, 9 dual-push cycles with DEPTH=16 -> 16 records retained, overflow=1, commit_cnt=16. Then a dual push with rec_ready=1 while full -> one accepted, one dropped.
- Trap drain: 3 REG commits, then trap_valid with a same-cycle store, rec_ready=1 -> exactly 4 records (3 REG, then TRAP), store discarded, done=1 after the TRAP pop, later wb_valid ignored.
- Pointer wrap: 40 single pushes with rec_ready toggling every cycle -> records pop in order with no loss, overflow=0, commit_cnt=40.
- Reset mid-stream: 5 records queued, reset=1 for one cycle -> rec_valid=0, commit_cnt=0, overflow=0, state RUN; the next push appears as the head record.

Source files
------------

// File: rtl/commit_trace_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// commit_trace_pkg : record kinds, packed commit record and FSM states
// Rev 1.0
// ---------------------------------------------------------------------------
package commit_trace_pkg;

  localparam int REC_XLEN = 32;

  localparam logic [1:0] KIND_REG   = 2'd0;
  localparam logic [1:0] KIND_LOAD  = 2'd1;
  localparam logic [1:0] KIND_STORE = 2'd2;
  localparam logic [1:0] KIND_TRAP  = 2'd3;

  typedef struct packed {
    logic [1:0]          kind;
    logic [REC_XLEN-1:0] pc;
    logic [31:0]         instr;
    logic [4:0]          rd;
    logic [REC_XLEN-1:0] data;
    logic [REC_XLEN-1:0] addr;
  } commit_rec_t;

  localparam int REC_W = $bits(commit_rec_t);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } trace_state_t;

  function automatic commit_rec_t make_rec(
    input logic [1:0]          kind,
    input logic [REC_XLEN-1:0] pc,
    input logic [31:0]         instr,
    input logic [4:0]          rd,
    input logic [REC_XLEN-1:0] data,
    input logic [REC_XLEN-1:0] addr
  );
    commit_rec_t r;
    r.kind  = kind;
    r.pc    = pc;
    r.instr = instr;
    r.rd    = rd;
    r.data  = data;
    r.addr  = addr;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/commit_trace_buffer_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trace_fifo_2w1r : dual-write, single-read show-ahead FIFO with count
// Rev 1.0
// ---------------------------------------------------------------------------
module trace_fifo_2w1r #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 135
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push0,
  input  logic [WIDTH-1:0]         data0,
  input  logic                     push1,
  input  logic [WIDTH-1:0]         data1,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [AW:0]      wptr1;
  logic [WIDTH-1:0] mem [DEPTH];

  // Second slot follows the first only when the first is also written.
  assign wptr1 = wptr + (AW+1)'(push0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + (AW+1)'(push0) + (AW+1)'(push1);
      if (pop) rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push0) mem[wptr[AW-1:0]]  <= data0;
    if (push1) mem[wptr1[AW-1:0]] <= data1;
  end

  assign head  = mem[rptr[AW-1:0]];
  assign count = wptr - rptr;
  assign empty = (count == '0);

endmodule
`default_nettype wire

// File: rtl/commit_trace_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// commit_trace_buffer : in-order architectural commit record stream
// Rev 1.0
// ---------------------------------------------------------------------------
module commit_trace_buffer
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic            wb_is_load,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [31:0]     wb_instr,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [XLEN-1:0] wb_addr,
  input  logic            st_valid,
  input  logic [XLEN-1:0] st_pc,
  input  logic [31:0]     st_instr,
  input  logic [XLEN-1:0] st_addr,
  input  logic [XLEN-1:0] st_data,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  output logic            rec_valid,
  input  logic            rec_ready,
  output logic [1:0]      rec_kind,
  output logic [XLEN-1:0] rec_pc,
  output logic [31:0]     rec_instr,
  output logic [4:0]      rec_rd,
  output logic [XLEN-1:0] rec_data,
  output logic [XLEN-1:0] rec_addr,
  output logic            overflow,
  output logic            done,
  output logic [31:0]     commit_cnt
);

  localparam int AW = $clog2(DEPTH);

  trace_state_t state, state_nx;
  commit_rec_t  wb_rec, st_rec, trap_rec, old_rec, slot0, slot1, head;
  logic         old_v, young_v, first_v, second_v;
  logic         acc0, acc1, drop, pop, empty;
  logic [AW:0]  count, free;

  assign wb_rec   = make_rec(wb_is_load ? KIND_LOAD : KIND_REG, wb_pc, wb_instr,
                             wb_rd, wb_data, wb_is_load ? wb_addr : '0);
  assign st_rec   = make_rec(KIND_STORE, st_pc, st_instr, 5'd0, st_data, st_addr);
  assign trap_rec = make_rec(KIND_TRAP, trap_pc, 32'd0, 5'd0, '0, '0);
  assign old_rec  = trap_valid ? trap_rec : wb_rec;

  assign rec_valid = !empty && (state != ST_DONE);
  assign pop       = rec_valid && rec_ready;
  assign free      = (AW+1)'(DEPTH) - count + (AW+1)'(pop);

  always_comb begin
    state_nx = state;
    old_v    = 1'b0;
    young_v  = 1'b0;
    first_v  = 1'b0;
    second_v = 1'b0;
    acc0     = 1'b0;
    acc1     = 1'b0;
    drop     = 1'b0;
    slot0    = '0;
    slot1    = '0;
    case (state)
      ST_RUN: begin
        // A store alongside a trap is younger than the trap and never commits.
        old_v    = wb_valid || trap_valid;
        young_v  = st_valid && !trap_valid;
        first_v  = old_v || young_v;
        second_v = old_v && young_v;
        slot0    = old_v ? old_rec : st_rec;
        slot1    = st_rec;
        acc0     = first_v && (free != '0);
        acc1     = second_v && (free >= (AW+1)'(2));
        drop     = (first_v && !acc0) || (second_v && !acc1) ||
                   (wb_valid && trap_valid);
        if (trap_valid) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Empty covers a trap that was dropped for lack of space.
        if ((pop && head.kind == KIND_TRAP) || empty) state_nx = ST_DONE;
      end
      default: state_nx = ST_DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      overflow   <= 1'b0;
      commit_cnt <= '0;
    end else begin
      state      <= state_nx;
      if (drop) overflow <= 1'b1;
      commit_cnt <= commit_cnt + 32'(acc0) + 32'(acc1);
    end
  end

  trace_fifo_2w1r #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push0 (acc0),
    .data0 (slot0),
    .push1 (acc1),
    .data1 (slot1),
    .pop   (pop),
    .head  (head),
    .count (count),
    .empty (empty)
  );

  assign done      = (state == ST_DONE);
  assign rec_kind  = rec_valid ? head.kind  : '0;
  assign rec_pc    = rec_valid ? head.pc    : '0;
  assign rec_instr = rec_valid ? head.instr : '0;
  assign rec_rd    = rec_valid ? head.rd    : '0;
  assign rec_data  = rec_valid ? head.data  : '0;
  assign rec_addr  = rec_valid ? head.addr  : '0;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_commit_trace_buffer : directed scoreboard bench for commit_trace_buffer
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_commit_trace_buffer;
  import commit_trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int XLEN  = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 0, wb_is_load = 0;
  logic [31:0] wb_pc = 0, wb_instr = 0, wb_data = 0, wb_addr = 0;
  logic [4:0]  wb_rd = 0;
  logic        st_valid = 0;
  logic [31:0] st_pc = 0, st_instr = 0, st_addr = 0, st_data = 0;
  logic        trap_valid = 0;
  logic [31:0] trap_pc = 0;
  logic        rec_valid, rec_ready = 0;
  logic [1:0]  rec_kind;
  logic [31:0] rec_pc, rec_instr, rec_data, rec_addr, commit_cnt;
  logic [4:0]  rec_rd;
  logic        overflow, done;

  commit_trace_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_is_load(wb_is_load), .wb_pc(wb_pc), .wb_instr(wb_instr),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_addr(wb_addr),
    .st_valid(st_valid), .st_pc(st_pc), .st_instr(st_instr), .st_addr(st_addr),
    .st_data(st_data), .trap_valid(trap_valid), .trap_pc(trap_pc),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind), .rec_pc(rec_pc),
    .rec_instr(rec_instr), .rec_rd(rec_rd), .rec_data(rec_data), .rec_addr(rec_addr),
    .overflow(overflow), .done(done), .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  commit_rec_t mq[$];
  int          mstate = 0;
  logic        movf = 1'b0;
  logic [31:0] mcnt = '0;

  task automatic chk(input string tag, input logic [134:0] obs, input logic [134:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    wb_valid = 0; wb_is_load = 0; st_valid = 0; trap_valid = 0;
  endtask

  task automatic set_wb(input logic ld, input logic [31:0] pc, input logic [4:0] rd,
                        input logic [31:0] data, input logic [31:0] addr);
    wb_valid = 1; wb_is_load = ld; wb_pc = pc; wb_instr = $urandom;
    wb_rd = rd; wb_data = data; wb_addr = addr;
  endtask

  task automatic set_st(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] data);
    st_valid = 1; st_pc = pc; st_instr = $urandom; st_addr = addr; st_data = data;
  endtask

  task automatic set_trap(input logic [31:0] pc);
    trap_valid = 1; trap_pc = pc;
  endtask

  task automatic check_outputs();
    logic        rv;
    commit_rec_t obs, exp;
    rv  = (mq.size() > 0) && (mstate != 2);
    obs = {rec_kind, rec_pc, rec_instr, rec_rd, rec_data, rec_addr};
    exp = rv ? mq[0] : '0;
    chk("rec_valid", rec_valid, rv);
    chk("record", obs, exp);
    chk("overflow", overflow, movf);
    chk("done", done, mstate == 2);
    chk("commit_cnt", commit_cnt, mcnt);
  endtask

  // One clock: check outputs, drive ready, update the reference model.
  task automatic step(input logic rdy);
    commit_rec_t newq[$];
    commit_rec_t r;
    logic        pop;
    int          free;
    @(negedge clk);
    check_outputs();
    rec_ready = rdy;
    pop = (mq.size() > 0) && (mstate != 2) && rdy;
    if (mstate == 0) begin
      if (trap_valid) begin
        r = '0; r.kind = KIND_TRAP; r.pc = trap_pc;
        newq.push_back(r);
        if (wb_valid) movf = 1'b1;
      end else if (wb_valid) begin
        r.kind = wb_is_load ? KIND_LOAD : KIND_REG; r.pc = wb_pc; r.instr = wb_instr;
        r.rd = wb_rd; r.data = wb_data; r.addr = wb_is_load ? wb_addr : 32'd0;
        newq.push_back(r);
      end
      if (st_valid && !trap_valid) begin
        r.kind = KIND_STORE; r.pc = st_pc; r.instr = st_instr; r.rd = 5'd0;
        r.data = st_data; r.addr = st_addr;
        newq.push_back(r);
      end
      free = DEPTH - mq.size() + (pop ? 1 : 0);
      if (trap_valid) mstate = 1;
    end else begin
      free = 0;
      if (mstate == 1 && ((pop && mq[0].kind == KIND_TRAP) || mq.size() == 0)) mstate = 2;
    end
    if (pop) void'(mq.pop_front());
    foreach (newq[i]) begin
      if (i < free) begin
        mq.push_back(newq[i]);
        mcnt++;
      end else begin
        movf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; rec_ready = 0;
    clear_inputs();
    @(posedge clk);
    #1;
    reset = 0;
    mq.delete(); mstate = 0; movf = 1'b0; mcnt = '0;
  endtask

  initial begin
    do_reset();
    chk("rst_valid", rec_valid, 1'b0);
    chk("rst_fields", {rec_kind, rec_pc, rec_instr, rec_rd, rec_data, rec_addr}, '0);
    chk("rst_cnt", commit_cnt, 32'd0);
    chk("rst_ovf_done", {overflow, done}, 2'b00);

    // Single REG commit; addr must be zeroed for REG.
    set_wb(0, 32'h8000_0000, 5'd5, 32'h1234_5678, 32'hFFFF_0000);
    step(1);
    chk("reg_kind", rec_kind, KIND_REG);
    chk("reg_rd_data", {rec_rd, rec_data, rec_addr}, {5'd5, 32'h1234_5678, 32'd0});
    chk("reg_cnt", commit_cnt, 32'd1);
    step(1);

    // Load + store in one cycle: load is older.
    set_wb(1, 32'h8000_0010, 5'd3, 32'hDEAD_BEEF, 32'h100);
    set_st(32'h8000_0014, 32'h104, 32'hCAFE_F00D);
    step(1);
    chk("ld_kind_addr", {rec_kind, rec_addr}, {KIND_LOAD, 32'h100});
    chk("ldst_cnt", commit_cnt, 32'd3);
    step(1);
    chk("st_kind_rd", {rec_kind, rec_rd, rec_data}, {KIND_STORE, 5'd0, 32'hCAFE_F00D});
    step(1);
    chk("ldst_empty", rec_valid, 1'b0);

    // Full FIFO: 9 dual pushes with no consumption.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_wb(0, 32'h100 + 8*i, 5'd1 + 5'(i), $urandom, $urandom);
      set_st(32'h104 + 8*i, $urandom, $urandom);
      step(0);
    end
    chk("full_ovf", overflow, 1'b1);
    chk("full_cnt", commit_cnt, 32'd16);
    set_wb(0, 32'h500, 5'd7, $urandom, 0);
    set_st(32'h504, $urandom, $urandom);
    step(1);
    chk("full_pop_cnt", commit_cnt, 32'd17);
    for (int i = 0; i < 18; i++) step(1);
    chk("full_drained", rec_valid, 1'b0);

    // Pointer wrap: 40 pushes, ready toggling.
    do_reset();
    for (int i = 0; i < 80; i++) begin
      if (i % 2 == 0) set_wb(0, 32'h2000 + 4*i, 5'd9, $urandom, $urandom);
      step(logic'(i % 2));
    end
    step(1);
    chk("wrap_ovf", overflow, 1'b0);
    chk("wrap_cnt", commit_cnt, 32'd40);

    // Trap drain with a same-cycle store.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_wb(0, 32'h3000 + 4*i, 5'd2, $urandom, 0);
      step(0);
    end
    set_trap(32'h300C);
    set_st(32'h3010, 32'h40, 32'h55);
    step(1);
    for (int i = 0; i < 6; i++) begin
      set_wb(0, 32'h3100, 5'd4, $urandom, 0);
      step(1);
    end
    chk("trap_done", done, 1'b1);
    chk("trap_cnt", commit_cnt, 32'd4);
    chk("trap_ovf", overflow, 1'b0);

    // Trap dropped into a full FIFO still finishes once drained.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_wb(0, 32'h4000 + 8*i, 5'd6, $urandom, 0);
      set_st(32'h4004 + 8*i, $urandom, $urandom);
      step(0);
    end
    set_trap(32'h4100);
    step(0);
    chk("tdrop_ovf", overflow, 1'b1);
    for (int i = 0; i < 18; i++) step(1);
    chk("tdrop_done", {done, commit_cnt}, {1'b1, 32'd16});

    // Trap and wb together: trap wins, wb dropped.
    do_reset();
    set_wb(0, 32'h5000, 5'd8, 32'h77, 0);
    set_trap(32'h5004);
    step(0);
    chk("conf_head", {rec_kind, rec_pc, overflow}, {KIND_TRAP, 32'h5004, 1'b1});
    step(1);
    step(1);

    // Reset mid-stream.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_wb(0, 32'h6000 + 4*i, 5'd10, $urandom, 0);
      step(0);
    end
    do_reset();
    chk("mid_rst", {rec_valid, commit_cnt, overflow, done}, '0);
    set_wb(0, 32'h7000, 5'd11, 32'hABCD, 0);
    step(0);
    chk("mid_head", {rec_valid, rec_pc, rec_rd}, {1'b1, 32'h7000, 5'd11});
    step(1);
    step(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
